// File: rtl/qerv_pkg.sv
// Shared encodings and sizing helpers for the qerv digit-serial datapath.
package qerv_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SLL = 2'd1,
        OP_SRL = 2'd2,
        OP_SRA = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    function automatic int ndig(input int w);
        return 32 / w;
    endfunction

    function automatic int cnt_w(input int w);
        return $clog2(32 / w);
    endfunction

endpackage

// File: rtl/qerv_digit_adder.sv
// W-bit digit adder with a registered carry chained between digits.
module qerv_digit_adder #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    logic         c_r;
    logic [W:0]   full;

    assign full  = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, c_r};
    assign o_sum = full[W-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            c_r <= 1'b0;
        else if (i_clr)
            c_r <= 1'b0;
        else if (i_en)
            c_r <= full[W];
    end

endmodule

// File: rtl/qerv_digit_bufreg.sv
// Digit-serial buffer register: serial ADD into data, serial shifted readout.
// Optional misalignment detect with `define QERV_BUFREG_MISALIGN_EN.
module qerv_digit_bufreg
    import qerv_pkg::*;
#(
    parameter int W   = 1,
    parameter int MDU = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_clr,
    input  logic [1:0]   i_op,
    input  logic         i_mdu_op,
    input  logic         i_rs1_en,
    input  logic         i_imm_en,
    input  logic         i_clr_lsb,
    input  logic [W-1:0] i_rs1,
    input  logic [W-1:0] i_imm,
    input  logic [4:0]   i_shamt,
    input  logic [1:0]   i_size,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_q,
    output logic [31:0]  o_dbus_adr,
    output logic [31:0]  o_ext_rs1,
    output logic [1:0]   o_lsb,
    output logic         o_misalign
);

    localparam int NDIG = ndig(W);
    localparam int CW   = cnt_w(W);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [31:0]   data;
    logic [1:0]    lsb_r;
    op_e           op_r;
    logic [4:0]    shamt_r;
    logic          busy_r;
    logic          done_r;

    logic [4:0]    base;
    logic [W-1:0]  rs1_d;
    logic [W-1:0]  imm_d;
    logic [W-1:0]  sum;
    logic [31:0]   shres;

    assign base  = 5'(int'(cnt) * W);
    assign rs1_d = i_rs1_en ? i_rs1 : '0;

    always_comb begin
        imm_d = i_imm_en ? i_imm : '0;
        if (i_clr_lsb && cnt == '0)
            imm_d[0] = 1'b0;
    end

    // Carry is held clear while idle so every phase starts from zero.
    qerv_digit_adder #(.W(W)) u_add (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_clr || state == ST_IDLE),
        .i_en  (state == ST_ADD),
        .i_a   (rs1_d),
        .i_b   (imm_d),
        .o_sum (sum)
    );

    always_comb begin
        unique case (op_r)
            OP_SLL:  shres = data << shamt_r;
            OP_SRL:  shres = data >> shamt_r;
            OP_SRA:  shres = 32'($signed(data) >>> shamt_r);
            default: shres = data;
        endcase
    end

    always_comb begin
        case (state)
            ST_ADD:   o_q = sum;
            ST_SHIFT: o_q = shres[base +: W];
            default:  o_q = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            data    <= '0;
            lsb_r   <= 2'b00;
            op_r    <= OP_ADD;
            shamt_r <= 5'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (i_clr) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state   <= (i_op == OP_ADD) ? ST_ADD : ST_SHIFT;
                        op_r    <= op_e'(i_op);
                        shamt_r <= i_shamt;
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    if (state == ST_ADD)
                        data[base +: W] <= sum;
                    if (cnt == LAST) begin
                        // Low bits were written in earlier digits.
                        if (state == ST_ADD)
                            lsb_r <= data[1:0];
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        done_r <= (cnt == LAST - CW'(1));
                    end
                end
            endcase
        end
    end

    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_dbus_adr = {data[31:2], 2'b00};
    assign o_ext_rs1  = data;
    assign o_lsb      = (MDU != 0 && i_mdu_op) ? 2'b00 : lsb_r;

`ifdef QERV_BUFREG_MISALIGN_EN
    assign o_misalign = (i_size == SZ_HALF && o_lsb[0]) ||
                        (i_size == SZ_WORD && o_lsb != 2'b00);
`else
    logic unused_size;
    assign unused_size = ^i_size;
    assign o_misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_qerv_digit_bufreg.sv
// Bench for qerv_digit_bufreg: W=1, W=4 (MDU=1) and W=8 run in lockstep.
module tb_qerv_digit_bufreg;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start, i_clr, i_mdu_op;
    logic       i_rs1_en, i_imm_en, i_clr_lsb;
    logic [1:0] i_op, i_size;
    logic [4:0] i_shamt;

    logic [7:0]  rs1_v [3];
    logic [7:0]  imm_v [3];
    logic [7:0]  q_v   [3];
    logic        busy_v[3];
    logic        done_v[3];
    logic [31:0] adr_v [3];
    logic [31:0] ext_v [3];
    logic [1:0]  lsb_v [3];
    logic        mis_v [3];

    always #5 i_clk = ~i_clk;

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int WW = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        logic [WW-1:0] q_g;
        assign q_v[g] = 8'(q_g);
        qerv_digit_bufreg #(.W(WW), .MDU((g == 1) ? 1 : 0)) dut (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_start    (i_start),
            .i_clr      (i_clr),
            .i_op       (i_op),
            .i_mdu_op   (i_mdu_op),
            .i_rs1_en   (i_rs1_en),
            .i_imm_en   (i_imm_en),
            .i_clr_lsb  (i_clr_lsb),
            .i_rs1      (rs1_v[g][WW-1:0]),
            .i_imm      (imm_v[g][WW-1:0]),
            .i_shamt    (i_shamt),
            .i_size     (i_size),
            .o_busy     (busy_v[g]),
            .o_done     (done_v[g]),
            .o_q        (q_g),
            .o_dbus_adr (adr_v[g]),
            .o_ext_rs1  (ext_v[g]),
            .o_lsb      (lsb_v[g]),
            .o_misalign (mis_v[g])
        );
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] dm;
    logic [1:0]  lsbm;
    logic [31:0] sbq[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ren;
        logic        ien;
        logic        clsb;
        logic [4:0]  sh;
        logic [31:0] exp;
        int          rs;
    } vec_t;

    vec_t tbl[14];

    function automatic int wd(input int j);
        return (j == 0) ? 1 : ((j == 1) ? 4 : 8);
    endfunction

    function automatic int nd(input int j);
        return 32 / wd(j);
    endfunction

    function automatic logic [1:0] lsb_exp(input int j);
        return (j == 1 && i_mdu_op) ? 2'b00 : lsbm;
    endfunction

    function automatic logic mis_exp(input logic [1:0] sz, input logic [1:0] l);
`ifdef QERV_BUFREG_MISALIGN_EN
        return (sz == 2'd1 && l[0]) || (sz == 2'd2 && l != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_idle_all(input string tag);
        for (int j = 0; j < 3; j++) begin
            chk({tag, " busy"}, 32'(busy_v[j]), 32'd0);
            chk({tag, " done"}, 32'(done_v[j]), 32'd0);
            chk({tag, " q"}, 32'(q_v[j]), 32'd0);
            chk({tag, " ext"}, ext_v[j], dm);
            chk({tag, " adr"}, adr_v[j], {dm[31:2], 2'b00});
            chk({tag, " lsb"}, 32'(lsb_v[j]), 32'(lsb_exp(j)));
            chk({tag, " mis"}, 32'(mis_v[j]), 32'(mis_exp(i_size, lsb_exp(j))));
        end
    endtask

    task automatic drive_digits(input logic [31:0] a, input logic [31:0] b, input int k);
        for (int j = 0; j < 3; j++) begin
            rs1_v[j] = (k < nd(j)) ? 8'(a >> (k * wd(j))) : 8'h00;
            imm_v[j] = (k < nd(j)) ? 8'(b >> (k * wd(j))) : 8'h00;
        end
    endtask

    task automatic run_phase(input vec_t v, input string tag);
        logic [31:0] got[3];
        logic [31:0] want;
        @(negedge i_clk);
        i_op = v.op; i_shamt = v.sh; i_start = 1'b1;
        i_rs1_en = v.ren; i_imm_en = v.ien; i_clr_lsb = v.clsb;
        for (int j = 2; j >= 0; j--) begin
            sbq.push_back(v.exp);
            got[j] = 32'd0;
        end
        for (int k = 0; k < 32; k++) begin
            @(negedge i_clk);
            i_start = (k == v.rs);
            i_op    = (k == v.rs) ? ~v.op : v.op;
            i_shamt = (k == v.rs) ? ~v.sh : v.sh;
            drive_digits(v.a, v.b, k);
            #1;
            for (int j = 0; j < 3; j++) begin
                if (k < nd(j)) begin
                    chk({tag, " busy"}, 32'(busy_v[j]), 32'd1);
                    chk({tag, " done"}, 32'(done_v[j]), 32'(k == nd(j) - 1));
                    got[j] |= (32'(q_v[j]) & ((32'd1 << wd(j)) - 1)) << (k * wd(j));
                    if (k == nd(j) - 1) begin
                        if (sbq.size() == 0) begin
                            chk({tag, " sb empty"}, 32'd1, 32'd0);
                        end else begin
                            want = sbq.pop_front();
                            chk({tag, " result"}, got[j], want);
                        end
                    end
                end else begin
                    chk({tag, " idle busy"}, 32'(busy_v[j]), 32'd0);
                    chk({tag, " idle q"}, 32'(q_v[j]), 32'd0);
                end
            end
        end
        @(negedge i_clk);
        i_start = 1'b0;
        drive_digits(32'd0, 32'd0, 0);
        if (v.op == 2'd0) begin
            dm   = v.exp;
            lsbm = v.exp[1:0];
        end
        #1;
        check_idle_all({tag, " end"});
    endtask

    vec_t vt;

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_clr = 1'b0; i_mdu_op = 1'b0;
        i_rs1_en = 1'b0; i_imm_en = 1'b0; i_clr_lsb = 1'b0;
        i_op = 2'd0; i_size = 2'd0; i_shamt = 5'd0;
        drive_digits(32'd0, 32'd0, 0);
        dm = 32'd0; lsbm = 2'b00;

        tbl[0]  = '{2'd0, 32'h0000_1003, 32'h0000_0FFF, 1, 1, 0, 5'd0,  32'h0000_2002, -1};
        tbl[1]  = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 0, 5'd0,  32'h0000_0000, -1};
        tbl[2]  = '{2'd0, 32'h8000_00F0, 32'h0000_0055, 1, 0, 0, 5'd0,  32'h8000_00F0, -1};
        tbl[3]  = '{2'd3, 32'h0,         32'h0,         0, 0, 0, 5'd4,  32'hF800_000F, -1};
        tbl[4]  = '{2'd2, 32'h0,         32'h0,         0, 0, 0, 5'd4,  32'h0800_000F, -1};
        tbl[5]  = '{2'd1, 32'h0,         32'h0,         0, 0, 0, 5'd31, 32'h0000_0000, -1};
        tbl[6]  = '{2'd1, 32'h0,         32'h0,         0, 0, 0, 5'd4,  32'h0000_0F00, 2};
        tbl[7]  = '{2'd3, 32'h0,         32'h0,         0, 0, 0, 5'd0,  32'h8000_00F0, -1};
        tbl[8]  = '{2'd0, 32'h0000_0010, 32'h0000_0003, 1, 1, 1, 5'd0,  32'h0000_0012, 2};
        tbl[9]  = '{2'd0, 32'h0000_0010, 32'h0000_0013, 1, 1, 1, 5'd0,  32'h0000_0022, -1};
        tbl[10] = '{2'd0, 32'h1234_5678, 32'h0F0F_0F0F, 1, 1, 0, 5'd0,  32'h2143_6587, -1};
        tbl[11] = '{2'd0, 32'hDEAD_0000, 32'h0000_0007, 0, 1, 0, 5'd0,  32'h0000_0007, -1};
        tbl[12] = '{2'd2, 32'h0,         32'h0,         0, 0, 0, 5'd1,  32'h0000_0003, 2};
        tbl[13] = '{2'd0, 32'h0000_1003, 32'h0000_0FFF, 1, 1, 0, 5'd0,  32'h0000_2002, -1};

        #1;
        check_idle_all("reset");
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check_idle_all("post reset");

        for (int i = 0; i < 14; i++)
            run_phase(tbl[i], $sformatf("vec%0d", i));

        // lsb=2: word misaligned, half/byte not; MDU instance forces lsb 0
        i_size = 2'd2; #1; check_idle_all("word lsb2");
        i_size = 2'd1; #1; check_idle_all("half lsb2");
        i_mdu_op = 1'b1;
        i_size = 2'd2; #1; check_idle_all("mdu word");
        i_mdu_op = 1'b0;
        vt = '{2'd0, 32'h0000_0001, 32'h0, 1, 0, 0, 5'd0, 32'h0000_0001, -1};
        run_phase(vt, "lsb1");
        i_size = 2'd1; #1; check_idle_all("half lsb1");
        i_size = 2'd0; #1; check_idle_all("byte lsb1");

        // abort at digit 3 while a carry is pending
        @(negedge i_clk);
        i_start = 1'b1; i_op = 2'd0; i_rs1_en = 1'b1; i_imm_en = 1'b1; i_clr_lsb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            drive_digits(32'hFFFF_FFFF, 32'h1, k);
            i_clr = (k == 3);
        end
        @(negedge i_clr == 1'b0 ? i_clk : i_clk);
        i_clr = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("clr busy", 32'(busy_v[j]), 32'd0);
            chk("clr q", 32'(q_v[j]), 32'd0);
        end
        vt = '{2'd0, 32'h0, 32'h0000_0005, 1, 1, 0, 5'd0, 32'h0000_0005, -1};
        run_phase(vt, "after clr");

        // reset at digit 5 of an ADD
        @(negedge i_clk);
        i_start = 1'b1; i_op = 2'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            drive_digits(32'h0000_FFFF, 32'h1, k);
        end
        #1;
        i_rst = 1'b1;
        #1;
        dm = 32'd0; lsbm = 2'b00;
        check_idle_all("mid rst");
        @(negedge i_clk);
        i_rst = 1'b0;
        vt = '{2'd0, 32'h0000_0007, 32'h0000_0001, 1, 1, 0, 5'd0, 32'h0000_0008, -1};
        run_phase(vt, "after rst");

        chk("sb drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
